uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial UART receiver, 8N1 format, LSB first.
- Sits downstream of the team's UART transmitter: consumes its serial line, or an external RX pin.
- Oversamples the line with the system clock and reassembles each byte.
- Presents the byte with a one-clock valid strobe, flags framing errors, and rejects glitch starts.

Parameters:
- CLKS_PER_BIT, 436, system clocks per bit period (50 MHz / 436 ≈ 115200 baud, matching the transmitter's divider of 218 clocks per half period).
- CNT_W, 9, width of the bit-period counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_in  in  1  serial line; idle high; asynchronous to clock.
- data_out  out  8  last received byte.
- valid  out  1  one-clock pulse: data_out updated with a good frame.
- frame_err  out  1  one-clock pulse: stop bit sampled low.
- busy  out  1  high from start-bit detection until return to IDLE.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset=0, immediate, no clock needed):
  - data_out=8'h00, valid=0, frame_err=0, busy=0.
  - FSM in IDLE, counters cleared, synchronizer flops set to 1.
- Synchronizer: rx_in passes through 2 flops; rx_s is the second flop. All decisions use rx_s only; input-to-decision latency is 2 clocks.
- Counters:
  - cnt (CNT_W bits): counts clocks within a bit; on reaching the terminal value it clears to 0, never wraps past it.
  - bit_idx (3 bits): data-bit index 0..7.
  - HALF = CLKS_PER_BIT/2, integer division, truncated.
- FSM states and transitions:
  - IDLE: busy=0. On rx_s=0: cnt←0, go START.
  - START: cnt counts up.
    - cnt==HALF-1 and rx_s=0: valid start. cnt←0, bit_idx←0, go DATA.
    - cnt==HALF-1 and rx_s=1: glitch. Go IDLE, no strobe.
  - DATA: at cnt==CLKS_PER_BIT-1 (mid-bit), shift rx_s into shift_reg[bit_idx], cnt←0.
    - bit_idx==7: go STOP.
    - otherwise bit_idx←bit_idx+1.
  - STOP: at cnt==CLKS_PER_BIT-1 (mid stop bit), cnt←0, go IDLE.
    - rx_s=1: data_out←shift_reg, valid=1 for exactly that clock.
    - rx_s=0: frame_err=1 for that clock; data_out unchanged.
- busy=1 in START, DATA, STOP.
- Latency: valid asserts ≈ 9.5 bit periods + 2 clocks after the falling edge of the start bit.
- Boundary cases:
  - valid and frame_err are never asserted together.
  - Both strobes are single-cycle, no handshake. Consumer must capture on the strobe; the next frame overwrites data_out.
  - rx_s still low after a framing error (break condition): IDLE treats it as a new start immediately. The resulting frame will also flag frame_err while the line stays low.
  - Back-to-back frames: a start edge arriving half a bit after the stop sample is accepted with no lost frame.
  - Line changes mid-bit are ignored; only the mid-bit sample counts.
  - reset asserted mid-frame: aborts immediately, no strobe.
  - Release of reset while rx_in=0: the first frame starts only after the synchronizer fills. A held-low line then enters START.

Test Plan:
- Single byte: CLKS_PER_BIT=16, drive frame 0xA5 (start, 1,0,1,0,0,1,0,1 LSB first, stop) → one valid pulse, data_out=8'hA5, frame_err=0, busy high ~160 clocks.
- Back-to-back: 0x00 then 0xFF with no idle gap → two valid pulses, data_out 8'h00 then 8'hFF, no frame_err.
- Glitch start: rx_in low for 3 clocks, then high (CLKS_PER_BIT=16) → FSM returns to IDLE, no valid, no frame_err, data_out unchanged.
- Framing error: frame 0x3C with stop bit driven 0 → frame_err pulse for 1 clock, valid=0, data_out keeps previous value 8'hA5.
- Reset mid-frame: assert reset=0 during bit 4 of a frame, release, then send 0x5A → outputs zero during reset; next frame gives data_out=8'h5A with exactly one valid.
- Loopback: transmitter output into rx_in, default CLKS_PER_BIT=436, bytes 0x00, 0x55, 0xAA, 0xFF → all four received in order, no frame_err.

Source files
------------

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 UART receiver, LSB first, mid-bit sampling with glitch-start
//            rejection, one-clock valid / frame_err strobes.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 436,
    parameter int CNT_W        = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic             sync1, rx_s;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shift_reg, shift_nxt;
    logic [7:0]       data_nxt;
    logic             valid_nxt, ferr_nxt;

    // Synchronizer resets to the idle line level so reset release is not a start.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx_in;
            rx_s  <= sync1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shift_reg <= shift_nxt;
            data_out  <= data_nxt;
            valid     <= valid_nxt;
            frame_err <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift_reg;
        data_nxt    = data_out;
        valid_nxt   = 1'b0;
        ferr_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    cnt_nxt   = '0;
                    state_nxt = START;
                end
            end
            START: begin
                if (cnt == HALF_M1) begin
                    cnt_nxt = '0;
                    if (!rx_s) begin
                        bit_idx_nxt = 3'd0;
                        state_nxt   = DATA;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == BIT_M1) begin
                    cnt_nxt            = '0;
                    shift_nxt[bit_idx] = rx_s;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == BIT_M1) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    if (rx_s) begin
                        data_nxt  = shift_reg;
                        valid_nxt = 1'b1;
                    end else begin
                        ferr_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Directed self-checking bench for uart_rx (fast 16-clock instance
//            plus a default-rate instance fed by a behavioural transmitter).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_a, rx_b;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b, ferr_a, ferr_b, busy_a, busy_b;

    int n_checks = 0;
    int n_errors = 0;

    int vcnt_a = 0, fcnt_a = 0, bcnt_a = 0;
    int vcnt_b = 0, fcnt_b = 0;
    int overlap = 0;
    logic [7:0] cap_a [64];
    logic [7:0] cap_b [64];

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(16), .CNT_W(5)) u_dut (
        .clock(clk), .reset(rst_n), .rx_in(rx_a), .data_out(data_a),
        .valid(valid_a), .frame_err(ferr_a), .busy(busy_a)
    );

    uart_rx u_dut_lb (
        .clock(clk), .reset(rst_n), .rx_in(rx_b), .data_out(data_b),
        .valid(valid_b), .frame_err(ferr_b), .busy(busy_b)
    );

    always @(negedge clk) begin
        if (valid_a) begin
            cap_a[vcnt_a % 64] <= data_a;
            vcnt_a <= vcnt_a + 1;
        end
        if (valid_b) begin
            cap_b[vcnt_b % 64] <= data_b;
            vcnt_b <= vcnt_b + 1;
        end
        if (ferr_a) fcnt_a <= fcnt_a + 1;
        if (ferr_b) fcnt_b <= fcnt_b + 1;
        if (busy_a) bcnt_a <= bcnt_a + 1;
        if ((valid_a && ferr_a) || (valid_b && ferr_b)) overlap <= overlap + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int lane, input logic b, input int clks);
        if (lane == 0) rx_a = b;
        else           rx_b = b;
        repeat (clks) @(negedge clk);
    endtask

    task automatic send_frame(input int lane, input logic [7:0] d, input logic stop);
        int clks;
        clks = (lane == 0) ? 16 : 436;
        drive(lane, 1'b0, clks);
        for (int i = 0; i < 8; i++) drive(lane, d[i], clks);
        drive(lane, stop, clks);
    endtask

    initial begin
        int v0, f0, b0;
        logic [7:0] lb_bytes [4];
        lb_bytes[0] = 8'h00; lb_bytes[1] = 8'h55; lb_bytes[2] = 8'hAA; lb_bytes[3] = 8'hFF;

        rst_n = 1'b0;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", 32'(data_a), 32'h00);
        check("rst_valid", 32'(valid_a), 32'h0);
        check("rst_ferr", 32'(ferr_a), 32'h0);
        check("rst_busy", 32'(busy_a), 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single byte 0xA5: busy spans start detect to stop sample (152 clocks)
        v0 = vcnt_a; f0 = fcnt_a; b0 = bcnt_a;
        send_frame(0, 8'hA5, 1'b1);
        repeat (4) @(negedge clk);
        check("a5_valid_cnt", 32'(vcnt_a - v0), 32'd1);
        check("a5_data", 32'(data_a), 32'hA5);
        check("a5_ferr_cnt", 32'(fcnt_a - f0), 32'd0);
        check("a5_busy_clks", 32'(bcnt_a - b0), 32'd152);

        // Glitch: 3 low clocks, START lasts 8 clocks then falls back to IDLE
        v0 = vcnt_a; f0 = fcnt_a; b0 = bcnt_a;
        rx_a = 1'b0;
        repeat (3) @(negedge clk);
        rx_a = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_valid_cnt", 32'(vcnt_a - v0), 32'd0);
        check("glitch_ferr_cnt", 32'(fcnt_a - f0), 32'd0);
        check("glitch_data", 32'(data_a), 32'hA5);
        check("glitch_busy_clks", 32'(bcnt_a - b0), 32'd8);
        check("glitch_idle", 32'(busy_a), 32'h0);

        // Framing error: low stop restarts at once, then rejects as a glitch
        v0 = vcnt_a; f0 = fcnt_a;
        send_frame(0, 8'h3C, 1'b0);
        rx_a = 1'b1;
        repeat (40) @(negedge clk);
        check("ferr_ferr_cnt", 32'(fcnt_a - f0), 32'd1);
        check("ferr_valid_cnt", 32'(vcnt_a - v0), 32'd0);
        check("ferr_data", 32'(data_a), 32'hA5);
        check("ferr_idle", 32'(busy_a), 32'h0);

        // Break: line held low 311 clocks gives two framing errors
        v0 = vcnt_a; f0 = fcnt_a;
        send_frame(0, 8'h00, 1'b0);
        repeat (151) @(negedge clk);
        rx_a = 1'b1;
        repeat (40) @(negedge clk);
        check("brk_ferr_cnt", 32'(fcnt_a - f0), 32'd2);
        check("brk_valid_cnt", 32'(vcnt_a - v0), 32'd0);
        check("brk_data", 32'(data_a), 32'hA5);

        // Back-to-back frames
        v0 = vcnt_a; f0 = fcnt_a;
        send_frame(0, 8'h00, 1'b1);
        send_frame(0, 8'hFF, 1'b1);
        repeat (4) @(negedge clk);
        check("b2b_valid_cnt", 32'(vcnt_a - v0), 32'd2);
        check("b2b_byte0", 32'(cap_a[v0 % 64]), 32'h00);
        check("b2b_byte1", 32'(cap_a[(v0 + 1) % 64]), 32'hFF);
        check("b2b_ferr_cnt", 32'(fcnt_a - f0), 32'd0);

        // Reset during bit 4 of a frame
        v0 = vcnt_a; f0 = fcnt_a;
        drive(0, 1'b0, 16);
        for (int i = 0; i < 4; i++) drive(0, 1'b1, 16);
        rx_a = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", 32'(data_a), 32'h00);
        check("mid_rst_busy", 32'(busy_a), 32'h0);
        check("mid_rst_valid", 32'(valid_a), 32'h0);
        check("mid_rst_ferr", 32'(ferr_a), 32'h0);
        rx_a = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_no_strobe", 32'(vcnt_a - v0 + fcnt_a - f0), 32'd0);
        v0 = vcnt_a;
        send_frame(0, 8'h5A, 1'b1);
        repeat (4) @(negedge clk);
        check("post_rst_valid_cnt", 32'(vcnt_a - v0), 32'd1);
        check("post_rst_data", 32'(data_a), 32'h5A);

        // Default-rate instance fed by a behavioural transmitter
        v0 = vcnt_b; f0 = fcnt_b;
        for (int i = 0; i < 4; i++) send_frame(1, lb_bytes[i], 1'b1);
        repeat (10) @(negedge clk);
        check("lb_valid_cnt", 32'(vcnt_b - v0), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("lb_byte%0d", i), 32'(cap_b[(v0 + i) % 64]), 32'(lb_bytes[i]));
        check("lb_ferr_cnt", 32'(fcnt_b - f0), 32'd0);

        check("strobe_overlap", 32'(overlap), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
